exu_oitf: RTL and testbench
===========================

Name: exu_oitf

Overview:
- Outstanding Instruction Track FIFO (OITF) for long-pipe (load/store) instructions.
- Allocates one in-order entry per long-pipe instruction at dispatch, returning its itag.
- Presents the oldest entry (itag, rdwen, rdidx) to the long-pipe write-back arbiter, and frees that entry when the arbiter asserts oitf_ret_ena.
- Flags RAW/WAW hazards between the dispatching instruction and all in-flight entries, so dispatch can stall.

Parameters:
OITF_DEPTH, 4, number of entries; must equal 2**`ITAG_WIDTH (power of two, >=2)

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
dis_ena  in  1  allocate entry this cycle (dispatch handshake fired for a long-pipe instr)
dis_ready  out  1  OITF not full; dispatcher may allocate
dis_ptr  out  `ITAG_WIDTH  itag of the entry allocated by dis_ena (current alloc index)
dis_rdwen  in  1  dispatching instr writes rd
dis_rdidx  in  `RFIDX_WIDTH  rd index of dispatching instr
oitf_empty  out  1  no valid entries
oitf_ret_ptr  out  `ITAG_WIDTH  itag of oldest entry
oitf_ret_rdwen  out  1  oldest entry writes rd
oitf_ret_rdidx  out  `RFIDX_WIDTH  rd index of oldest entry
oitf_ret_ena  in  1  retire oldest entry
disp_i_rs1en  in  1  dispatching instr reads rs1
disp_i_rs2en  in  1  dispatching instr reads rs2
disp_i_rdwen  in  1  dispatching instr writes rd (WAW check)
disp_i_rs1idx  in  `RFIDX_WIDTH  rs1 index
disp_i_rs2idx  in  `RFIDX_WIDTH  rs2 index
disp_i_rdidx  in  `RFIDX_WIDTH  rd index
oitfrd_match_disprs1  out  1  RAW hazard on rs1
oitfrd_match_disprs2  out  1  RAW hazard on rs2
oitfrd_match_disprd  out  1  WAW hazard on rd

Behaviour:
- Storage: per entry, vld, rdwen and rdidx registers.
- Pointers:
  - alc_ptr and ret_ptr are `ITAG_WIDTH index plus 1 wrap bit each.
  - Increment wraps the index to 0 and toggles the wrap bit.
- Derived status:
  - empty = (index equal) & (wrap equal).
  - full = (index equal) & (wrap differ).
  - dis_ready = ~full.
- Reset (rst_n low at a clk edge):
  - Both pointers go to 0; all vld, rdwen and rdidx go to 0.
  - Resulting outputs: oitf_empty=1, dis_ready=1, dis_ptr=0, oitf_ret_ptr=0, oitf_ret_rdwen=0, oitf_ret_rdidx=0, all match outputs 0.
  - A reset mid-operation discards all in-flight entries.
- Allocate: alc = dis_ena & ~full.
  - On the edge: entry[alc_idx] gets vld=1, rdwen=dis_rdwen, rdidx=dis_rdidx; alc_ptr increments.
  - dis_ena while full is ignored; no state change.
- Retire: ret = oitf_ret_ena & ~empty.
  - On the edge: entry[ret_idx].vld goes to 0; ret_ptr increments.
  - oitf_ret_ena while empty is ignored.
- Simultaneous alloc and ret:
  - Both occur, and occupancy is unchanged.
  - When full, alloc is still blocked by the current-cycle full, even if a retire fires in the same cycle. No bypass.
  - When empty, a same-cycle alloc is not visible on the ret outputs until the next cycle.
- Read outputs:
  - dis_ptr = alc_ptr index, combinational from state.
  - oitf_ret_ptr = ret_ptr index.
  - oitf_ret_rdwen/rdidx come from entry[ret_idx], forced to 0 when empty.
  - An allocated entry becomes visible to retire and hazard logic one cycle after alloc. A retired entry stops matching one cycle after ret.
- Hazard match, purely combinational OR over all entries:
  - An entry hits if vld & rdwen & (rdidx == idx) & (idx != 0).
  - oitfrd_match_disprs1 = rs1en & hit(rs1idx); rs2 likewise.
  - oitfrd_match_disprd = disp_i_rdwen & hit(rdidx).
  - x0 never matches.
- Occupancy never exceeds OITF_DEPTH; no counter besides the pointers.

Decomposition:
- defines.v, shared by all exu modules, already carries `ITAG_WIDTH and `RFIDX_WIDTH; add `OITF_DEPTH there.
- One natural sub-module: exu_oitf_ptr, a wrap-bit pointer register with enable, sync active-low reset to 0, and outputs index and wrap. It is instantiated twice (alloc, retire).

Test Plan:
- Reset then idle → oitf_empty=1, dis_ready=1, dis_ptr=0, oitf_ret_rdwen=0, all matches 0.
- Alloc rdwen=1 rdidx=5, then rdwen=0 rdidx=7 → dis_ptr goes 0 then 1. Next cycle: ret_ptr=0, ret_rdwen=1, ret_rdidx=5. After ret: ret_ptr=1, ret_rdwen=0, ret_rdidx=7.
- Four allocs (rdidx 1..4) → dis_ready=0. A 5th dis_ena is ignored (dis_ptr stays 0). Ret plus dis_ena in the same cycle → only ret happens. Next cycle: dis_ready=1.
- Alloc/ret pairs for 9 cycles → dis_ptr/ret_ptr wrap 3→0 and track equal. Empty/full are never asserted erroneously across the wrap.
- Entry rdidx=9 in flight, rs1idx=9 rs1en=1 → match_disprs1=1. Same with rs1en=0 → 0. disp_i_rdidx=9 rdwen=1 → match_disprd=1. Entry with rdidx=0, rdwen=1 and rs2idx=0 → match_disprs2=0.
- Three entries in flight, rst_n=0 for one cycle → next cycle: empty=1, dis_ptr=0, all matches 0.

Source files
------------

// File: rtl/exu_oitf_pkg.sv
// exu_oitf_pkg: shared sizing and entry type for the outstanding instruction
// track FIFO (OITF).
//   ITAG_WIDTH  : bits of an OITF entry tag (index into the FIFO)
//   RFIDX_WIDTH : register-file index width
//   OITF_DEPTH  : entry count, always 2**ITAG_WIDTH so pointers wrap naturally
package exu_oitf_pkg;
  localparam int ITAG_WIDTH  = 2;
  localparam int RFIDX_WIDTH = 5;
  localparam int OITF_DEPTH  = 1 << ITAG_WIDTH;

  // Destination info tracked per in-flight long-pipe instruction.
  typedef struct packed {
    logic                   rdwen;
    logic [RFIDX_WIDTH-1:0] rdidx;
  } oitf_ent_t;
endpackage

// File: rtl/exu_oitf_ptr.sv
// exu_oitf_ptr: circular FIFO pointer with a wrap bit.
//   clk, rst_n : clock, synchronous active-low reset (pointer -> 0)
//   inc_i      : advance pointer this cycle
//   idx_o      : entry index
//   wrap_o     : toggles every time idx_o wraps back to 0
module exu_oitf_ptr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] idx_o,
  output logic         wrap_o
);
  logic [W-1:0] idx_q, idx_d;
  logic         wrap_q, wrap_d;

  // Depth is a power of two, so carrying out of the index into the wrap
  // bit is exactly "index wraps to 0, wrap toggles".
  always_comb begin
    {wrap_d, idx_d} = {wrap_q, idx_q};
    if (inc_i) {wrap_d, idx_d} = {wrap_q, idx_q} + (W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
    end
  end

  assign idx_o  = idx_q;
  assign wrap_o = wrap_q;
endmodule

// File: rtl/exu_oitf.sv
// exu_oitf: in-order tracker for outstanding long-pipe (load/store) instrs.
//   clk, rst_n          : clock, synchronous active-low reset
//   dis_ena/dis_ready   : allocate an entry / FIFO not full
//   dis_ptr             : itag handed to the allocating instruction
//   dis_rdwen/dis_rdidx : destination info stored in the new entry
//   oitf_empty          : no entries in flight
//   oitf_ret_*          : oldest entry, presented to the write-back arbiter
//   oitf_ret_ena        : retire (free) the oldest entry
//   disp_i_*            : operand/dest info of the instr being dispatched
//   oitfrd_match_*      : RAW (rs1/rs2) and WAW (rd) hazard flags
module exu_oitf
  import exu_oitf_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   dis_ena,
  output logic                   dis_ready,
  output logic [ITAG_WIDTH-1:0]  dis_ptr,
  input  logic                   dis_rdwen,
  input  logic [RFIDX_WIDTH-1:0] dis_rdidx,
  output logic                   oitf_empty,
  output logic [ITAG_WIDTH-1:0]  oitf_ret_ptr,
  output logic                   oitf_ret_rdwen,
  output logic [RFIDX_WIDTH-1:0] oitf_ret_rdidx,
  input  logic                   oitf_ret_ena,
  input  logic                   disp_i_rs1en,
  input  logic                   disp_i_rs2en,
  input  logic                   disp_i_rdwen,
  input  logic [RFIDX_WIDTH-1:0] disp_i_rs1idx,
  input  logic [RFIDX_WIDTH-1:0] disp_i_rs2idx,
  input  logic [RFIDX_WIDTH-1:0] disp_i_rdidx,
  output logic                   oitfrd_match_disprs1,
  output logic                   oitfrd_match_disprs2,
  output logic                   oitfrd_match_disprd
);
  logic [ITAG_WIDTH-1:0] alc_idx, ret_idx;
  logic                  alc_wrap, ret_wrap;
  logic                  full, empty, alc, ret;

  oitf_ent_t [OITF_DEPTH-1:0] ent_q;
  logic      [OITF_DEPTH-1:0] vld_q;

  // Status uses current-cycle state only: a retire does not free a slot
  // for an alloc in the same cycle, and a fresh alloc is not retirable yet.
  assign empty = (alc_idx == ret_idx) && (alc_wrap == ret_wrap);
  assign full  = (alc_idx == ret_idx) && (alc_wrap != ret_wrap);
  assign alc   = dis_ena && !full;
  assign ret   = oitf_ret_ena && !empty;

  exu_oitf_ptr #(.W(ITAG_WIDTH)) u_alc_ptr (
    .clk(clk), .rst_n(rst_n), .inc_i(alc), .idx_o(alc_idx), .wrap_o(alc_wrap)
  );
  exu_oitf_ptr #(.W(ITAG_WIDTH)) u_ret_ptr (
    .clk(clk), .rst_n(rst_n), .inc_i(ret), .idx_o(ret_idx), .wrap_o(ret_wrap)
  );

  // alc and ret never target the same slot in one cycle: equal indices
  // means empty (ret blocked) or full (alc blocked).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      ent_q <= '0;
    end else begin
      for (int i = 0; i < OITF_DEPTH; i++) begin
        if (alc && (alc_idx == ITAG_WIDTH'(i))) begin
          vld_q[i]       <= 1'b1;
          ent_q[i].rdwen <= dis_rdwen;
          ent_q[i].rdidx <= dis_rdidx;
        end else if (ret && (ret_idx == ITAG_WIDTH'(i))) begin
          vld_q[i] <= 1'b0;
        end
      end
    end
  end

  // Hazard match: any live, rd-writing entry targeting the same nonzero reg.
  logic [OITF_DEPTH-1:0] hit_rs1, hit_rs2, hit_rd;
  always_comb begin
    hit_rs1 = '0;
    hit_rs2 = '0;
    hit_rd  = '0;
    for (int i = 0; i < OITF_DEPTH; i++) begin
      hit_rs1[i] = vld_q[i] && ent_q[i].rdwen && (ent_q[i].rdidx == disp_i_rs1idx)
                   && (disp_i_rs1idx != '0);
      hit_rs2[i] = vld_q[i] && ent_q[i].rdwen && (ent_q[i].rdidx == disp_i_rs2idx)
                   && (disp_i_rs2idx != '0);
      hit_rd[i]  = vld_q[i] && ent_q[i].rdwen && (ent_q[i].rdidx == disp_i_rdidx)
                   && (disp_i_rdidx != '0);
    end
  end

  assign oitfrd_match_disprs1 = disp_i_rs1en && (|hit_rs1);
  assign oitfrd_match_disprs2 = disp_i_rs2en && (|hit_rs2);
  assign oitfrd_match_disprd  = disp_i_rdwen && (|hit_rd);

  assign dis_ready      = !full;
  assign dis_ptr        = alc_idx;
  assign oitf_empty     = empty;
  assign oitf_ret_ptr   = ret_idx;
  assign oitf_ret_rdwen = !empty && ent_q[ret_idx].rdwen;
  assign oitf_ret_rdidx = empty ? '0 : ent_q[ret_idx].rdidx;
endmodule

// File: tb/tb_exu_oitf.sv
// tb_exu_oitf: drives exu_oitf with directed and random traffic and compares
// every output each cycle against a queue-based model of the FIFO.
module tb_exu_oitf;
  import exu_oitf_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   dis_ena, dis_ready, dis_rdwen;
  logic [ITAG_WIDTH-1:0]  dis_ptr, oitf_ret_ptr;
  logic [RFIDX_WIDTH-1:0] dis_rdidx, oitf_ret_rdidx;
  logic                   oitf_empty, oitf_ret_rdwen, oitf_ret_ena;
  logic                   disp_i_rs1en, disp_i_rs2en, disp_i_rdwen;
  logic [RFIDX_WIDTH-1:0] disp_i_rs1idx, disp_i_rs2idx, disp_i_rdidx;
  logic                   m_rs1, m_rs2, m_rd;

  always #5 clk = ~clk;

  exu_oitf dut (
    .clk(clk), .rst_n(rst_n),
    .dis_ena(dis_ena), .dis_ready(dis_ready), .dis_ptr(dis_ptr),
    .dis_rdwen(dis_rdwen), .dis_rdidx(dis_rdidx),
    .oitf_empty(oitf_empty), .oitf_ret_ptr(oitf_ret_ptr),
    .oitf_ret_rdwen(oitf_ret_rdwen), .oitf_ret_rdidx(oitf_ret_rdidx),
    .oitf_ret_ena(oitf_ret_ena),
    .disp_i_rs1en(disp_i_rs1en), .disp_i_rs2en(disp_i_rs2en),
    .disp_i_rdwen(disp_i_rdwen), .disp_i_rs1idx(disp_i_rs1idx),
    .disp_i_rs2idx(disp_i_rs2idx), .disp_i_rdidx(disp_i_rdidx),
    .oitfrd_match_disprs1(m_rs1), .oitfrd_match_disprs2(m_rs2),
    .oitfrd_match_disprd(m_rd)
  );

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: FIFO of in-flight entries plus running alloc/ret counts.
  typedef struct { bit rdwen; int rdidx; } ment_t;
  ment_t q[$];
  int alc_n = 0, ret_n = 0;

  function automatic bit mhit(input int idx);
    if (idx == 0) return 1'b0;
    foreach (q[k]) if (q[k].rdwen && q[k].rdidx == idx) return 1'b1;
    return 1'b0;
  endfunction

  // Called #1 after negedge with inputs already applied.
  task automatic check_all();
    chk("empty",    oitf_empty,     q.size() == 0);
    chk("ready",    dis_ready,      q.size() < OITF_DEPTH);
    chk("dis_ptr",  dis_ptr,        alc_n % OITF_DEPTH);
    chk("ret_ptr",  oitf_ret_ptr,   ret_n % OITF_DEPTH);
    chk("ret_rdwen", oitf_ret_rdwen, q.size() == 0 ? 0 : q[0].rdwen);
    chk("ret_rdidx", oitf_ret_rdidx, q.size() == 0 ? 0 : q[0].rdidx);
    chk("m_rs1", m_rs1, disp_i_rs1en && mhit(disp_i_rs1idx));
    chk("m_rs2", m_rs2, disp_i_rs2en && mhit(disp_i_rs2idx));
    chk("m_rd",  m_rd,  disp_i_rdwen && mhit(disp_i_rdidx));
  endtask

  // One clock: check, take the edge, advance the model, return at negedge.
  task automatic cyc();
    bit do_alc, do_ret;
    #1;
    check_all();
    @(posedge clk);
    if (!rst_n) begin
      q.delete(); alc_n = 0; ret_n = 0;
    end else begin
      do_alc = dis_ena && q.size() < OITF_DEPTH;
      do_ret = oitf_ret_ena && q.size() > 0;
      if (do_ret) begin void'(q.pop_front()); ret_n++; end
      if (do_alc) begin q.push_back('{dis_rdwen, int'(dis_rdidx)}); alc_n++; end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rst_n = 1; dis_ena = 0; dis_rdwen = 0; dis_rdidx = 0; oitf_ret_ena = 0;
    disp_i_rs1en = 0; disp_i_rs2en = 0; disp_i_rdwen = 0;
    disp_i_rs1idx = 0; disp_i_rs2idx = 0; disp_i_rdidx = 0;
  endtask

  task automatic alloc(input bit w, input int idx);
    dis_ena = 1; dis_rdwen = w; dis_rdidx = RFIDX_WIDTH'(idx);
  endtask

  initial begin
    idle();
    rst_n = 0;
    @(posedge clk); @(negedge clk);
    rst_n = 1;
    // Reset state
    #1;
    chk("rst_empty", oitf_empty, 1); chk("rst_ready", dis_ready, 1);
    chk("rst_dptr", dis_ptr, 0);     chk("rst_rdwen", oitf_ret_rdwen, 0);
    cyc();

    // Two allocs, then two retires
    alloc(1, 5); #1 chk("dptr0", dis_ptr, 0); cyc();
    alloc(0, 7); #1 chk("dptr1", dis_ptr, 1); cyc();
    idle(); #1 chk("ret5", oitf_ret_rdidx, 5); cyc();
    oitf_ret_ena = 1; cyc();
    #1 chk("retptr1", oitf_ret_ptr, 1); chk("ret7", oitf_ret_rdidx, 7);
    cyc(); idle(); cyc();

    // Fill, blocked alloc, ret + blocked alloc
    for (int i = 1; i <= 4; i++) begin alloc(1, i); cyc(); end
    idle(); #1 chk("full_ready", dis_ready, 0);
    alloc(1, 20); cyc();
    #1 chk("blocked_dptr", dis_ptr, 2);  // alc_n was 6 -> index 2
    alloc(1, 21); oitf_ret_ena = 1; cyc();
    idle(); #1 chk("after_ret_ready", dis_ready, 1); cyc();
    oitf_ret_ena = 1; for (int i = 0; i < 4; i++) cyc();
    idle();

    // Paired alloc/ret across the wrap
    alloc(1, 3); cyc();
    for (int i = 0; i < 9; i++) begin alloc(1, i + 1); oitf_ret_ena = 1; cyc(); end
    idle(); oitf_ret_ena = 1; cyc(); idle();

    // Hazards
    alloc(1, 9); cyc(); alloc(1, 0); cyc(); idle();
    disp_i_rs1en = 1; disp_i_rs1idx = 9; #1 chk("raw_rs1", m_rs1, 1); cyc();
    disp_i_rs1en = 0; cyc();
    disp_i_rdwen = 1; disp_i_rdidx = 9; #1 chk("waw_rd", m_rd, 1); cyc();
    disp_i_rs2en = 1; disp_i_rs2idx = 0; #1 chk("x0_rs2", m_rs2, 0); cyc();

    // Reset mid-operation
    idle(); alloc(1, 12); cyc(); idle();
    disp_i_rs1en = 1; disp_i_rs1idx = 12; rst_n = 0; cyc();
    rst_n = 1; #1 chk("midrst_empty", oitf_empty, 1); chk("midrst_m", m_rs1, 0); cyc();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      rst_n         = ($urandom_range(0, 99) != 0);
      dis_ena       = ($urandom_range(0, 9) < 6);
      dis_rdwen     = ($urandom_range(0, 3) != 0);
      dis_rdidx     = RFIDX_WIDTH'($urandom_range(0, 7));
      oitf_ret_ena  = ($urandom_range(0, 1) == 1);
      disp_i_rs1en  = $urandom_range(0, 1);
      disp_i_rs2en  = $urandom_range(0, 1);
      disp_i_rdwen  = $urandom_range(0, 1);
      disp_i_rs1idx = RFIDX_WIDTH'($urandom_range(0, 7));
      disp_i_rs2idx = RFIDX_WIDTH'($urandom_range(0, 7));
      disp_i_rdidx  = RFIDX_WIDTH'($urandom_range(0, 7));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
